// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if
// Purpose: bundles the host command/response handshake and the RAM-chip
//          bus of ram_bus_master into one interface.
// Signals:
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op[3:0]               RAM/IO opcode (WRM..RD3)
//   cmd_addr[7:0]             {chip[7:6], reg[5:4], char[3:0]}
//   cmd_wdata[3:0]            write nibble
//   rsp_valid/rsp_rdata[3:0]  completion pulse and read nibble
//   sync, cm_ram              instruction-cycle marker and RAM command line
//   dbus_out[3:0]             nibble driven toward the RAM chips
//   dbus_in[3:0]              OR of all RAM chips' outputs
// Modports: master = the bus master itself, slave = host plus RAM chips.
interface ram_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       sync;
  logic       cm_ram;
  logic [3:0] dbus_out;
  logic [3:0] dbus_in;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, dbus_in,
    output cmd_ready, rsp_valid, rsp_rdata, sync, cm_ram, dbus_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, dbus_in,
    input  cmd_ready, rsp_valid, rsp_rdata, sync, cm_ram, dbus_out
  );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master
// Purpose: turns single host RAM/IO commands into MCS-4 style eight-phase
//          instruction cycles (SRC to select an address, then the I/O
//          instruction) toward i4002-type RAM chips.
// Parameters:
//   SKIP_SRC  when nonzero, the SRC cycle is omitted if the command targets
//             the address selected by the most recent SRC.
// Ports:
//   clk   single clock, rising-edge
//   rst   synchronous active-high reset
//   bus   ram_bus_master_if.master (command, response and RAM bus signals)
module ram_bus_master #(
  parameter int SKIP_SRC = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_bus_master_if.master  bus
);

  // Instruction-cycle phases
  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SRC  = 2'd1;
  localparam logic [1:0] ST_IO   = 2'd2;

  // OPR codes placed on the bus in M1
  localparam logic [3:0] OPR_SRC = 4'h2;
  localparam logic [3:0] OPR_IO  = 4'hE;

  // Read-type OPA codes
  localparam logic [3:0] OP_SBM = 4'h8;
  localparam logic [3:0] OP_RDM = 4'h9;
  localparam logic [3:0] OP_RDR = 4'hA;
  localparam logic [3:0] OP_ADM = 4'hB;
  localparam logic [3:0] OP_RD0 = 4'hC;
  localparam logic [3:0] OP_RD1 = 4'hD;
  localparam logic [3:0] OP_RD2 = 4'hE;
  localparam logic [3:0] OP_RD3 = 4'hF;

  // Opcodes for which the RAM drives data back in X2
  function automatic logic is_read_op(input logic [3:0] op);
    logic rd;
    case (op)
      OP_SBM, OP_RDM, OP_RDR, OP_ADM,
      OP_RD0, OP_RD1, OP_RD2, OP_RD3: rd = 1'b1;
      default:                        rd = 1'b0;
    endcase
    return rd;
  endfunction

  logic [2:0] r_phase;
  logic [1:0] r_state;
  logic [3:0] r_op;
  logic [7:0] r_addr;
  logic [3:0] r_wdata;
  logic [7:0] r_last_addr;
  logic       r_last_valid;

  logic       r_sync;
  logic       r_cmd_ready;
  logic       r_cm_ram;
  logic [3:0] r_dbus_out;
  logic       r_rsp_valid;
  logic [3:0] r_rsp_rdata;

  logic [2:0] w_phase_nxt;
  logic       w_accept;
  logic       w_skip;
  logic       w_sync_nxt;
  logic       w_ready_nxt;
  logic       w_cm_nxt;
  logic [3:0] w_dout_nxt;
  logic       w_rsp_valid_nxt;
  logic [3:0] w_rsp_rdata_nxt;

  // The 3-bit counter wraps X3 -> A1 on its own.
  assign w_phase_nxt = r_phase + 3'd1;
  // r_cmd_ready is only ever high in X3 of IDLE/IO, so this also gates on phase.
  assign w_accept    = bus.cmd_valid && r_cmd_ready;
  assign w_skip      = (SKIP_SRC != 0) && r_last_valid && (bus.cmd_addr == r_last_addr);

  // Bus values for the phase about to start; outputs are registered from these
  // so every output depends only on phase, state and the latched command.
  // A1 always yields all zeros, which hides the state change at the X3 edge.
  always_comb begin
    w_sync_nxt      = (w_phase_nxt == PH_X3);
    w_ready_nxt     = (w_phase_nxt == PH_X3) && ((r_state == ST_IDLE) || (r_state == ST_IO));
    w_cm_nxt        = 1'b0;
    w_dout_nxt      = 4'h0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = 4'h0;
    case (r_state)
      ST_SRC: begin
        case (w_phase_nxt)
          PH_M1: w_dout_nxt = OPR_SRC;
          PH_M2: w_dout_nxt = 4'h1;
          PH_X2: begin
            w_dout_nxt = r_addr[3:0];
            w_cm_nxt   = 1'b1;
          end
          PH_X3:   w_dout_nxt = r_addr[7:4];
          default: w_dout_nxt = 4'h0;
        endcase
      end
      ST_IO: begin
        case (w_phase_nxt)
          PH_M1: w_dout_nxt = OPR_IO;
          PH_M2: begin
            w_dout_nxt = r_op;
            w_cm_nxt   = 1'b1;
          end
          PH_X2: begin
            if (is_read_op(r_op)) begin
              w_dout_nxt = 4'h0;
            end else begin
              w_dout_nxt = r_wdata;
            end
          end
          PH_X3: begin
            // Loading here is the capture of dbus_in at the edge ending X2.
            w_rsp_valid_nxt = 1'b1;
            if (is_read_op(r_op)) begin
              w_rsp_rdata_nxt = bus.dbus_in;
            end else begin
              w_rsp_rdata_nxt = 4'h0;
            end
          end
          default: w_dout_nxt = 4'h0;
        endcase
      end
      default: w_dout_nxt = 4'h0;
    endcase
  end

  // Phase counter, FSM and command/last-address registers; state moves only at X3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= PH_A1;
      r_state      <= ST_IDLE;
      r_op         <= 4'h0;
      r_addr       <= 8'h00;
      r_wdata      <= 4'h0;
      r_last_addr  <= 8'h00;
      r_last_valid <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      if (r_phase == PH_X3) begin
        case (r_state)
          ST_SRC: begin
            r_last_addr  <= r_addr;
            r_last_valid <= 1'b1;
            r_state      <= ST_IO;
          end
          ST_IDLE, ST_IO: begin
            if (w_accept) begin
              r_op    <= bus.cmd_op;
              r_addr  <= bus.cmd_addr;
              r_wdata <= bus.cmd_wdata;
              r_state <= w_skip ? ST_IO : ST_SRC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_cm_ram    <= 1'b0;
      r_dbus_out  <= 4'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 4'h0;
    end else begin
      r_sync      <= w_sync_nxt;
      r_cmd_ready <= w_ready_nxt;
      r_cm_ram    <= w_cm_nxt;
      r_dbus_out  <= w_dout_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign bus.sync      = r_sync;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.cm_ram    = r_cm_ram;
  assign bus.dbus_out  = r_dbus_out;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ram_bus_master.sv
// tb_ram_bus_master
// Purpose: self-checking bench for ram_bus_master. Two instances are built,
//          SKIP_SRC=0 and SKIP_SRC=1, each with a behavioural RAM-chip
//          responder (chips 0..2 present, chip 3 absent). Every cycle of each
//          instruction cycle is compared against the expected bus pattern;
//          read data comes from a reference memory updated per completed IO.
module tb_ram_bus_master;

  localparam int K_IDLE = 0;
  localparam int K_SRC  = 1;
  localparam int K_IO   = 2;
  localparam int NO_ABORT = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_clr = 1'b1;
  logic       sel = 1'b1;
  logic       t_valid = 1'b0;
  logic [3:0] t_op = 4'h0;
  logic [7:0] t_addr = 8'h00;
  logic [3:0] t_wd = 4'h0;

  // {sync, cmd_ready, cm_ram, dbus_out[3:0], rsp_valid, rsp_rdata[3:0]}
  logic [11:0] obs [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] ref_mem [2048];
  int         m_kind;
  logic [3:0] m_op;
  logic [7:0] m_addr;
  logic [3:0] m_wd;
  logic [3:0] m_rd;
  logic [7:0] m_last_addr;
  logic       m_last_valid;

  always #5 clk = ~clk;

  // Storage index: main characters or status characters (op[2]) of one chip/reg.
  function automatic logic [10:0] mem_key(input logic g, input logic [3:0] op, input logic [7:0] addr);
    logic [9:0] k;
    if (op[2]) k = {4'b1000, addr[7:4], op[1:0]};
    else       k = {2'b00, addr};
    return {g, k};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_bus_master_if u_if ();
    logic [2:0]  rp;
    logic [3:0]  m1, rop, rchar, rcr, din;
    logic [3:0]  rmem [1024];
    logic [10:0] w_key;

    ram_bus_master #(.SKIP_SRC(g)) u_dut (.clk(clk), .rst(rst), .bus(u_if));

    assign u_if.cmd_valid = (int'(sel) == g) ? t_valid : 1'b0;
    assign u_if.cmd_op    = t_op;
    assign u_if.cmd_addr  = t_addr;
    assign u_if.cmd_wdata = t_wd;
    assign u_if.dbus_in   = din;
    assign obs[g] = {u_if.sync, u_if.cmd_ready, u_if.cm_ram, u_if.dbus_out,
                     u_if.rsp_valid, u_if.rsp_rdata};
    assign w_key = mem_key(g == 1, rop, {rcr, rchar});

    // i4002-like responder: follows sync, decodes SRC/IO, stores and returns nibbles.
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) rmem[i] <= 4'h0;
      end
      if (rst) begin
        rp  <= 3'd0;
        din <= 4'h0;
        m1  <= 4'h0;
        rop <= 4'h0;
      end else begin
        rp  <= u_if.sync ? 3'd0 : rp + 3'd1;
        din <= 4'h0;
        case (rp)
          3'd3: m1 <= u_if.dbus_out;
          3'd4: if (m1 == 4'hE && u_if.cm_ram) rop <= u_if.dbus_out;
          3'd5: if (m1 == 4'hE && rop[3] && rcr[3:2] != 2'b11 && rop != 4'hA) din <= rmem[w_key[9:0]];
          3'd6: begin
            if (m1 == 4'h2 && u_if.cm_ram) rchar <= u_if.dbus_out;
            else if (m1 == 4'hE && !rop[3] && rcr[3:2] != 2'b11 && (rop == 4'h0 || rop[2]))
              rmem[w_key[9:0]] <= u_if.dbus_out;
          end
          3'd7: if (m1 == 4'h2) rcr <= u_if.dbus_out;
          default: ;
        endcase
      end
    end
  end

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ram_read(input logic g, input logic [3:0] op, input logic [7:0] addr);
    if (addr[7:6] == 2'b11 || op == 4'hA) return 4'h0;
    return ref_mem[mem_key(g, op, addr)];
  endfunction

  task automatic ram_write(input logic g, input logic [3:0] op, input logic [7:0] addr, input logic [3:0] wd);
    if (addr[7:6] != 2'b11 && (op == 4'h0 || op[3:2] == 2'b01)) ref_mem[mem_key(g, op, addr)] = wd;
  endtask

  // Expected bus pattern for one phase of one instruction-cycle kind.
  function automatic logic [11:0] exp_vec(input int kind, input int p, input logic [3:0] op,
                                          input logic [7:0] addr, input logic [3:0] wd, input logic [3:0] rd);
    logic sy, rdy, cm, rv;
    logic [3:0] d, rr;
    sy = (p == 7); rdy = (p == 7) && (kind != K_SRC);
    cm = 1'b0; d = 4'h0; rv = 1'b0; rr = 4'h0;
    if (kind == K_SRC) begin
      if (p == 3) d = 4'h2;
      if (p == 4) d = 4'h1;
      if (p == 6) begin d = addr[3:0]; cm = 1'b1; end
      if (p == 7) d = addr[7:4];
    end else if (kind == K_IO) begin
      if (p == 3) d = 4'hE;
      if (p == 4) begin d = op; cm = 1'b1; end
      if (p == 6) d = op[3] ? 4'h0 : wd;
      if (p == 7) begin rv = 1'b1; rr = op[3] ? rd : 4'h0; end
    end
    return {sy, rdy, cm, d, rv, rr};
  endfunction

  // One instruction cycle: check all 8 phases, offer a command in X3, then
  // advance the model. abort_at raises rst in that phase and returns early.
  task automatic run_icycle(input logic nv, input logic [3:0] nop, input logic [7:0] naddr,
                            input logic [3:0] nwd, input logic hold, input int abort_at);
    for (int p = 0; p < 8; p++) begin
      check_val($sformatf("dut%0d k%0d ph%0d", sel, m_kind, p), obs[sel],
                exp_vec(m_kind, p, m_op, m_addr, m_wd, m_rd));
      if (p == abort_at) begin
        rst = 1'b1;
        t_valid = 1'b0;
        return;
      end
      if (p == 7 || hold) begin
        t_valid = nv; t_op = nop; t_addr = naddr; t_wd = nwd;
      end else begin
        t_valid = 1'($urandom); t_op = 4'($urandom); t_addr = 8'($urandom); t_wd = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    if (m_kind == K_SRC) begin
      m_last_addr = m_addr; m_last_valid = 1'b1; m_kind = K_IO;
    end else begin
      if (m_kind == K_IO) ram_write(sel, m_op, m_addr, m_wd);
      if (nv) begin
        m_op = nop; m_addr = naddr; m_wd = nwd;
        m_rd = ram_read(sel, nop, naddr);
        m_kind = (sel && m_last_valid && naddr == m_last_addr) ? K_IO : K_SRC;
      end else begin
        m_kind = K_IDLE;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    t_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("reset dut%0d", sel), obs[sel], 12'h000);
    end
    rst = 1'b0;
    m_kind = K_IDLE;
    m_last_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    run_icycle(1'b0, 4'h0, 8'h00, 4'h0, 1'b0, NO_ABORT);
  endtask

  task automatic random_run(input int n);
    logic [7:0] pool [8];
    pool = '{8'h25, 8'h10, 8'hC0, 8'h4F, 8'h83, 8'h25, 8'h10, 8'hA7};
    for (int i = 0; i < n; i++) begin
      run_icycle($urandom_range(0, 3) != 0, 4'($urandom), pool[$urandom_range(0, 7)],
                 4'($urandom), 1'($urandom), NO_ABORT);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = 4'h0;
    m_kind = K_IDLE; m_op = 4'h0; m_addr = 8'h00; m_wd = 4'h0; m_rd = 4'h0;
    m_last_addr = 8'h00; m_last_valid = 1'b0;

    // SKIP_SRC=1 instance
    sel = 1'b1;
    do_reset(4);
    mem_clr = 1'b0;
    idle_cycle(); idle_cycle(); idle_cycle();
    // WRM 0x25 <- 0xA, then RDM 0x25 back to back (SRC skipped)
    run_icycle(1'b1, 4'h0, 8'h25, 4'hA, 1'b0, NO_ABORT);
    run_icycle(1'b1, 4'h9, 8'h25, 4'h0, 1'b0, NO_ABORT);   // SRC: offer must be ignored
    run_icycle(1'b1, 4'h9, 8'h25, 4'h0, 1'b0, NO_ABORT);   // IO WRM: RDM accepted
    run_icycle(1'b0, 4'h0, 8'h00, 4'h0, 1'b0, NO_ABORT);   // IO RDM
    // WR2 0x10 <- 7 then RD2 0x10 with cmd_valid held
    run_icycle(1'b1, 4'h6, 8'h10, 4'h7, 1'b1, NO_ABORT);
    run_icycle(1'b1, 4'hE, 8'h10, 4'h0, 1'b1, NO_ABORT);
    run_icycle(1'b1, 4'hE, 8'h10, 4'h0, 1'b1, NO_ABORT);
    run_icycle(1'b0, 4'h0, 8'h00, 4'h0, 1'b0, NO_ABORT);
    // RDM from absent chip 3
    run_icycle(1'b1, 4'h9, 8'hC0, 4'h0, 1'b0, NO_ABORT);
    idle_cycle(); idle_cycle();
    // WRM 0x25 <- 3 aborted by reset in IO M2, then RDM 0x25 must re-issue SRC
    run_icycle(1'b1, 4'h0, 8'h25, 4'h3, 1'b0, NO_ABORT);
    idle_cycle();                                          // SRC 0x25
    run_icycle(1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4);          // IO, reset at M2
    do_reset(3);
    run_icycle(1'b1, 4'h9, 8'h25, 4'h0, 1'b0, NO_ABORT);
    idle_cycle(); idle_cycle(); idle_cycle();
    random_run(80);

    // SKIP_SRC=0 instance
    sel = 1'b0;
    do_reset(2);
    run_icycle(1'b1, 4'h0, 8'h25, 4'hA, 1'b0, NO_ABORT);
    idle_cycle();
    run_icycle(1'b1, 4'h9, 8'h25, 4'h0, 1'b0, NO_ABORT);
    idle_cycle(); idle_cycle(); idle_cycle();
    random_run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 SHALL have parameter SKIP_SRC, default 1, which when 1 omits the SRC instruction if the target address equals the last one sent.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  host command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high at a rising edge.
REQ-006 SHALL have port cmd_op  input  4  RAM/IO opcode, encoded as the mcs4 OPA constants (WRM..RD3).
REQ-007 SHALL have port cmd_addr  input  8  {chip[7:6], reg[5:4], char[3:0]}.
REQ-008 SHALL have port cmd_wdata  input  4  write nibble.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  4  read nibble; 0 for write ops.
REQ-011 SHALL have port sync  output  1  instruction-cycle marker to RAM chips.
REQ-012 SHALL have port cm_ram  output  1  RAM command line.
REQ-013 SHALL have port dbus_out  output  4  nibble driven toward the RAM chips.
REQ-014 SHALL have port dbus_in  input  4  OR of all RAM chips' dbus_out.

Function
REQ-015 SHALL keep a 3-bit phase counter encoded as A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7, incrementing every cycle and wrapping from 7 to 0.
REQ-016 SHALL assert sync exactly in phase X3 of every instruction cycle, including idle ones, so RAM chips see phase A1 in the next cycle.
REQ-017 SHALL have FSM states IDLE, SRC and IO, with transitions only at the X3 rising edge.
REQ-018 SHALL assert cmd_ready only in phase X3 while in state IDLE or IO, and never while rst is high.
REQ-019 On accept, SHALL register op, addr and wdata, then go to SRC; if SKIP_SRC=1, addr equals last_addr and last_valid is set, SHALL go directly to IO.
REQ-020 SHALL run an IDLE instruction cycle as: dbus_out=0 and cm_ram=0 in all phases.
REQ-021 SHALL run an SRC instruction cycle as: M1 dbus_out=0x2; M2 dbus_out=0x1 with cm_ram=0; X2 dbus_out=char with cm_ram=1; X3 dbus_out={chip,reg} with cm_ram=0; dbus_out=0 in all other phases.
REQ-022 At the end of SRC, SHALL set last_addr=addr and last_valid=1, then go to IO.
REQ-023 SHALL run an IO instruction cycle as: M1 dbus_out=0xE; M2 dbus_out=op with cm_ram=1; X2 dbus_out=wdata for write ops or 0 for read ops; cm_ram=0 and dbus_out=0 in all other phases.
REQ-024 SHALL treat SBM, RDM, RDR, ADM and RD0-RD3 as read ops and all other opcodes as write ops.
REQ-025 For read ops, SHALL capture dbus_in at the rising edge ending X2.
REQ-026 SHALL assert rsp_valid for exactly the X3 cycle of IO, with rsp_rdata holding the captured nibble for reads and 0 for writes.
REQ-027 At the end of IO, SHALL go to SRC/IO if a command is accepted in the same X3 cycle, else to IDLE.
REQ-028 Because of REQ-027, back-to-back commands SHALL need no idle instruction cycle between them.
REQ-029 SHALL derive sync, cm_ram, dbus_out, rsp_* and cmd_ready only from registered phase, state and command; there SHALL be no combinational path from the cmd_* inputs to any output.
REQ-030 SHALL ignore cmd_valid outside phase X3 and SHALL NOT require it to be held.

Reset
REQ-031 While rst is high: phase=A1, state=IDLE, last_valid=0, and all outputs=0.
REQ-032 On the first cycle after reset, SHALL be in phase A1; the first sync SHALL occur at the 8th cycle after reset release, and the first cmd_ready at that same cycle.
REQ-033 Reset mid-command SHALL abort it with no rsp_valid; the next command after reset SHALL always issue SRC.

Verification
REQ-034 Reset, then idle 3 instruction cycles -> sync high at cycles 8, 16 and 24 after reset release, cm_ram never high, dbus_out=0.
REQ-035 WRM addr=0x25 wdata=0xA, with an i4002 of RAM_ID 0 attached -> SRC with X2=0x5 and X3=0x2, then IO with M2=WRM and X2=0xA; rsp_valid at IO X3 with rsp_rdata=0.
REQ-036 RDM addr=0x25 following REQ-035 with SKIP_SRC=1 -> no SRC cycle; rsp_rdata=0xA; with SKIP_SRC=0 -> SRC is reissued and the result is the same.
REQ-037 Back-to-back WR2 addr=0x10 wdata=0x7 then RD2 addr=0x10, with cmd_valid held -> second command accepted in the same cycle as the first rsp_valid; second response rsp_rdata=0x7.
REQ-038 RDM addr=0xC0, i.e. chip 3 with no chip present -> rsp_rdata=0x0; rst asserted at phase M2 of an IO cycle -> no rsp_valid, and the next command issues SRC.
